// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latching, maskable, fixed-priority interrupt controller
// Raw requests are synchronised, rising edges latched as pending, and one source at a time is presented and tracked to EOI.
module interrupt_controller #(
  parameter int N_IRQ       = 8,
  parameter int VEC_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             eoi,
  input  logic             overrun_clr,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vector,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] overrun_q, overrun_d;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] in_service_q;
  logic             irq_q;
  logic [VEC_W-1:0] vec_q;
  state_t           state_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] vec_onehot;
  logic [N_IRQ-1:0] ack_clr;
  logic [VEC_W-1:0] sel;
  logic             ack_fire;

  assign rise       = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign elig       = pending_q & ~mask_q;
  assign vec_onehot = N_IRQ'(1) << vec_q;
  assign ack_fire   = (state_q == S_REQ) && irq_ack;
  assign ack_clr    = ack_fire ? vec_onehot : '0;

  // Lowest index wins: scan downwards so the last hit is the lowest set bit.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = VEC_W'(i);
    end
  end

  // An edge consumed by a same-cycle ack re-arms pending without counting as overrun.
  always_comb begin
    pending_d = (pending_q & ~ack_clr) | rise;
    overrun_d = (overrun_clr ? '0 : overrun_q) | (rise & pending_q & ~ack_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '1;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      irq_q        <= 1'b0;
      vec_q        <= '0;
      in_service_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (elig != '0) begin
            state_q <= S_REQ;
            irq_q   <= 1'b1;
            vec_q   <= sel;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            state_q      <= S_SERVICE;
            irq_q        <= 1'b0;
            in_service_q <= vec_onehot;
          end else if (mask_q[vec_q]) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            state_q      <= S_IDLE;
            in_service_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = irq_q;
  assign irq_vector = vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_ack;
  logic       eoi;
  logic       overrun_clr;
  logic       irq;
  logic [2:0] irq_vector;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] overrun;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(.N_IRQ(8), .VEC_W(3), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .irq_ack     (irq_ack),
    .eoi         (eoi),
    .overrun_clr (overrun_clr),
    .irq         (irq),
    .irq_vector  (irq_vector),
    .pending     (pending),
    .in_service  (in_service),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse the given lines for one cycle and wait until the edge lands in pending.
  task automatic edge_in(input logic [7:0] bits);
    irq_in = irq_in | bits;
    tick();
    irq_in = irq_in & ~bits;
    tick();
    tick();
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0; overrun_clr = 1'b0;
    tick();
    check("rst_irq", irq, 1'b0);
    check("rst_vec", irq_vector, 3'd0);
    check("rst_pend", pending, 8'h00);
    check("rst_insvc", in_service, 8'h00);
    check("rst_ovr", overrun, 8'h00);
    reset = 1'b1;
    tick();

    // 1: single edge on bit 3 through the full handshake
    write_mask(8'h00);
    pulse_ack();
    pulse_eoi();
    check("t1_stray_ack", in_service, 8'h00);
    edge_in(8'h08);
    check("t1_pend", pending, 8'h08);
    check("t1_irq_lat", irq, 1'b0);
    tick();
    check("t1_irq", irq, 1'b1);
    check("t1_vec", irq_vector, 3'd3);
    pulse_ack();
    check("t1_pend_ack", pending, 8'h00);
    check("t1_insvc", in_service, 8'h08);
    check("t1_irq_ack", irq, 1'b0);
    pulse_ack();
    check("t1_ack_in_svc", in_service, 8'h08);
    pulse_eoi();
    check("t1_eoi", in_service, 8'h00);
    tick();
    check("t1_idle", irq, 1'b0);

    // 2: simultaneous edges served in priority order
    edge_in(8'h22);
    check("t2_pend", pending, 8'h22);
    tick();
    check("t2_irq1", irq, 1'b1);
    check("t2_vec1", irq_vector, 3'd1);
    pulse_ack();
    check("t2_pend1", pending, 8'h20);
    check("t2_insvc1", in_service, 8'h02);
    pulse_eoi();
    check("t2_gap", irq, 1'b0);
    tick();
    check("t2_irq5", irq, 1'b1);
    check("t2_vec5", irq_vector, 3'd5);
    pulse_ack();
    check("t2_pend5", pending, 8'h00);
    check("t2_insvc5", in_service, 8'h20);
    pulse_eoi();

    // 3: reset mask blocks requests until software unmasks
    do_reset();
    edge_in(8'h01);
    check("t3_pend", pending, 8'h01);
    tick();
    check("t3_masked", irq, 1'b0);
    write_mask(8'hFE);
    check("t3_mask_lat", irq, 1'b0);
    tick();
    check("t3_irq", irq, 1'b1);
    check("t3_vec", irq_vector, 3'd0);
    pulse_ack();
    pulse_eoi();
    write_mask(8'h00);

    // 4: second edge while pending sets overrun, only one service
    edge_in(8'h04);
    check("t4_pend", pending, 8'h04);
    tick();
    check("t4_vec", irq_vector, 3'd2);
    edge_in(8'h04);
    check("t4_ovr", overrun, 8'h04);
    check("t4_pend2", pending, 8'h04);
    check("t4_irq_hold", irq, 1'b1);
    pulse_ack();
    check("t4_insvc", in_service, 8'h04);
    check("t4_pend_ack", pending, 8'h00);
    pulse_eoi();
    tick();
    check("t4_once", irq, 1'b0);
    check("t4_ovr_sticky", overrun, 8'h04);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t4_ovr_clr", overrun, 8'h00);

    // 5: masking the selected source in REQ withdraws it
    edge_in(8'h50);
    tick();
    check("t5_irq4", irq, 1'b1);
    check("t5_vec4", irq_vector, 3'd4);
    write_mask(8'h10);
    check("t5_hold", irq, 1'b1);
    tick();
    check("t5_drop", irq, 1'b0);
    tick();
    check("t5_irq6", irq, 1'b1);
    check("t5_vec6", irq_vector, 3'd6);
    pulse_ack();
    check("t5_pend", pending, 8'h10);
    check("t5_insvc", in_service, 8'h40);
    pulse_eoi();

    // 6: asynchronous reset during SERVICE
    write_mask(8'h00);
    tick();
    check("t6_vec", irq_vector, 3'd4);
    pulse_ack();
    check("t6_insvc", in_service, 8'h10);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_insvc", in_service, 8'h00);
    check("t6_async_irq", irq, 1'b0);
    check("t6_async_pend", pending, 8'h00);
    check("t6_async_vec", irq_vector, 3'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("t6_no_irq", irq, 1'b0);
    edge_in(8'h01);
    tick();
    check("t6_mask_ff", irq, 1'b0);
    check("t6_pend", pending, 8'h01);

    // 7: ack coinciding with a fresh edge on the same bit
    do_reset();
    write_mask(8'h00);
    edge_in(8'h02);
    tick();
    check("t7_vec", irq_vector, 3'd1);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    pulse_ack();
    check("t7_pend", pending, 8'h02);
    check("t7_ovr", overrun, 8'h00);
    check("t7_insvc", in_service, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
